// File: rtl/mem_dp_be.sv
// Simple dual-port RAM with per-byte write enables and an RD_LAT-stage read pipeline.
// Adds global response backpressure, a read-during-write policy and out-of-range flagging.
module mem_dp_be #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err
);
    localparam int NB = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             ready_q;
    logic [WIDTH-1:0] data_p [RD_LAT];
    logic             err_p  [RD_LAT];
    logic             vld_p  [RD_LAT];

    logic             stall;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             rdw_hit;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] rd_word;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_word,
                                                     input logic [WIDTH-1:0] new_word,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

    assign rsp_valid = vld_p[RD_LAT-1];
    assign rsp_data  = data_p[RD_LAT-1];
    assign rsp_err   = err_p[RD_LAT-1];

    // One stalled response freezes the whole pipeline; bubbles are not squeezed out.
    assign stall    = rsp_valid && !rsp_ready;
    assign wr_ready = ready_q;
    assign rd_ready = ready_q && !stall;
    assign wr_fire  = wr_valid && wr_ready && !res;
    assign rd_fire  = rd_valid && rd_ready && !res;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

    assign wr_old    = wr_in_range ? mem[wr_addr] : '0;
    assign wr_merged = merge_bytes(wr_old, wr_data, wr_be);
    assign rdw_hit   = (RDW_MODE != 0) && wr_fire && wr_in_range && (wr_addr == rd_addr);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = rdw_hit ? wr_merged : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                vld_p[s]  <= 1'b0;
                data_p[s] <= '0;
                err_p[s]  <= 1'b0;
            end
        end else begin
            ready_q <= 1'b1;
            if (wr_fire && wr_in_range) mem[wr_addr] <= wr_merged;
            // stage 0 captures the memory word at the accepting edge
            if (!stall) begin
                vld_p[0] <= rd_fire;
                if (rd_fire) begin
                    data_p[0] <= rd_word;
                    err_p[0]  <= !rd_in_range;
                end
                // stages 1..RD_LAT-1 shift forward together
                for (int s = 1; s < RD_LAT; s++) begin
                    vld_p[s]  <= vld_p[s-1];
                    data_p[s] <= data_p[s-1];
                    err_p[s]  <= err_p[s-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_dp_be.sv
// Bench for mem_dp_be: instance A (DEPTH 16, RD_LAT 1, old-data RDW) and instance B
// (DEPTH 12, RD_LAT 3, new-data RDW) share stimulus; each has its own transaction-level model.
module tb_mem_dp_be;
    logic        clk = 1'b0;
    logic        res;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_valid;
    logic [3:0]  rd_addr;
    logic        rsp_ready;

    logic        wr_ready_w  [2];
    logic        rd_ready_w  [2];
    logic        rsp_valid_w [2];
    logic [31:0] rsp_data_w  [2];
    logic        rsp_err_w   [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_dp_be #(.WIDTH(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .res(res),
        .wr_valid(wr_valid), .wr_ready(wr_ready_w[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready_w[0]), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_w[0]), .rsp_err(rsp_err_w[0])
    );

    mem_dp_be #(.WIDTH(32), .DEPTH(12), .RD_LAT(3), .RDW_MODE(1)) dut_b (
        .clk(clk), .res(res),
        .wr_valid(wr_valid), .wr_ready(wr_ready_w[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready_w[1]), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_w[1]), .rsp_err(rsp_err_w[1])
    );

    // Reference model: word array plus an ordered list of accepted reads, each carrying
    // the number of unstalled edges still needed before it reaches the output.
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cnt;
    } txn_t;

    txn_t        fifo  [2][8];
    int          fcnt  [2];
    logic [31:0] mm    [2][16];
    logic        rdy_m [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    task automatic model_reset(input int k);
        fcnt[k]  = 0;
        rdy_m[k] = 1'b0;
        for (int i = 0; i < 16; i++) mm[k][i] = 32'h0;
    endtask

    task automatic model_check(input int k);
        logic head;
        head = (fcnt[k] > 0) && (fifo[k][0].cnt == 0);
        chk($sformatf("rsp_valid[%0d]", k), {31'b0, rsp_valid_w[k]}, {31'b0, head});
        chk($sformatf("wr_ready[%0d]", k), {31'b0, wr_ready_w[k]}, {31'b0, rdy_m[k]});
        chk($sformatf("rd_ready[%0d]", k), {31'b0, rd_ready_w[k]},
            {31'b0, rdy_m[k] && !(head && !rsp_ready)});
        if (head) begin
            chk($sformatf("rsp_data[%0d]", k), rsp_data_w[k], fifo[k][0].d);
            chk($sformatf("rsp_err[%0d]", k), {31'b0, rsp_err_w[k]}, {31'b0, fifo[k][0].e});
        end
    endtask

    task automatic model_step(input int k);
        int          lat;
        int          dep;
        logic        rdw_new;
        logic        head;
        logic        stall;
        logic        wf;
        logic        rf;
        logic        rerr;
        logic [31:0] rword;
        lat     = (k == 0) ? 1 : 3;
        dep     = (k == 0) ? 16 : 12;
        rdw_new = (k == 1);
        head    = (fcnt[k] > 0) && (fifo[k][0].cnt == 0);
        stall   = head && !rsp_ready;
        if (res) begin
            model_reset(k);
            return;
        end
        wf    = wr_valid && rdy_m[k];
        rf    = rd_valid && rdy_m[k] && !stall;
        rerr  = int'(rd_addr) >= dep;
        rword = rerr ? 32'h0 : mm[k][rd_addr];
        if (!rerr && rdw_new && wf && wr_addr == rd_addr) rword = apply_be(rword, wr_data, wr_be);
        if (!stall) begin
            if (head) begin
                for (int i = 1; i < fcnt[k]; i++) fifo[k][i-1] = fifo[k][i];
                fcnt[k]--;
            end
            for (int i = 0; i < fcnt[k]; i++) fifo[k][i].cnt--;
        end
        if (rf) begin
            fifo[k][fcnt[k]] = '{rword, rerr, lat - 1};
            fcnt[k]++;
        end
        if (wf && int'(wr_addr) < dep) mm[k][wr_addr] = apply_be(mm[k][wr_addr], wr_data, wr_be);
        rdy_m[k] = 1'b1;
    endtask

    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) model_check(k);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_addr = 4'd0; wr_data = 32'h0; wr_be = 4'h0;
        rd_valid = 1'b0; rd_addr = 4'd0;
    endtask

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wbe;
        logic        rv;
        logic [3:0]  ra;
        logic        a_rv;
        logic [31:0] a_d;
        logic        b_rv;
        logic [31:0] b_d;
        logic        b_err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 4'd3,  32'h00AA0000, 4'h4, 1'b0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'hDEAABEEF, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 4'd5,  32'h11223344, 4'hF, 1'b1, 4'd5,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  1'b1, 32'h11223344, 1'b1, 32'hDEAABEEF, 1'b0};
        tbl[5]  = '{1'b1, 4'd7,  32'hFFFFFFFF, 4'h0, 1'b1, 4'd7,  1'b1, 32'h0,        1'b1, 32'h11223344, 1'b0};
        tbl[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  1'b1, 32'h0,        1'b1, 32'h11223344, 1'b0};
        tbl[7]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 4'd15, 32'hA5A5A5A5, 4'h9, 1'b1, 4'd3,  1'b1, 32'hDEAABEEF, 1'b1, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd15, 1'b1, 32'hA50000A5, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0};
        tbl[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1};

        res = 1'b1; rsp_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        model_reset(0);
        model_reset(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr_ready in reset[%0d]", k), {31'b0, wr_ready_w[k]}, 32'h0);
            chk($sformatf("rd_ready in reset[%0d]", k), {31'b0, rd_ready_w[k]}, 32'h0);
        end
        tick();
        res = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr_ready up[%0d]", k), {31'b0, wr_ready_w[k]}, 32'h1);
            chk($sformatf("rd_ready up[%0d]", k), {31'b0, rd_ready_w[k]}, 32'h1);
        end

        // every word reads back zero after reset
        for (int a = 0; a < 16; a++) begin
            rd_valid = 1'b1; rd_addr = 4'(a);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < 12; i++) begin
            wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_be = tbl[i].wbe;
            rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
            tick();
            chk($sformatf("tbl%0d A valid", i), {31'b0, rsp_valid_w[0]}, {31'b0, tbl[i].a_rv});
            if (tbl[i].a_rv) chk($sformatf("tbl%0d A data", i), rsp_data_w[0], tbl[i].a_d);
            chk($sformatf("tbl%0d B valid", i), {31'b0, rsp_valid_w[1]}, {31'b0, tbl[i].b_rv});
            if (tbl[i].b_rv) begin
                chk($sformatf("tbl%0d B data", i), rsp_data_w[1], tbl[i].b_d);
                chk($sformatf("tbl%0d B err", i), {31'b0, rsp_err_w[1]}, {31'b0, tbl[i].b_err});
            end
        end

        // latency 3 on B: back-to-back reads of 1,2,3
        idle_inputs();
        for (int a = 1; a <= 3; a++) begin
            wr_valid = 1'b1; wr_addr = 4'(a); wr_data = 32'h101 * a; wr_be = 4'hF;
            tick();
        end
        idle_inputs();
        rd_valid = 1'b1;
        rd_addr = 4'd1; tick();
        chk("lat B C+1", {31'b0, rsp_valid_w[1]}, 32'h0);
        rd_addr = 4'd2; tick();
        chk("lat B C+2", {31'b0, rsp_valid_w[1]}, 32'h0);
        rd_addr = 4'd3; tick();
        chk("lat B C+3 valid", {31'b0, rsp_valid_w[1]}, 32'h1);
        chk("lat B C+3 data", rsp_data_w[1], 32'h101);

        // backpressure with three reads in flight; a write to addr 2 lands meanwhile
        rsp_ready = 1'b0; rd_addr = 4'd4;
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0BAD; wr_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall B rd_ready", {31'b0, rd_ready_w[1]}, 32'h0);
            chk("stall B valid", {31'b0, rsp_valid_w[1]}, 32'h1);
            chk("stall B data", rsp_data_w[1], 32'h101);
        end
        idle_inputs();
        rsp_ready = 1'b1;
        tick();
        chk("release B data1", rsp_data_w[1], 32'h202);
        tick();
        chk("release B data2", rsp_data_w[1], 32'h303);
        tick();
        chk("release B drained", {31'b0, rsp_valid_w[1]}, 32'h0);

        // out-of-range on B (DEPTH 12)
        wr_valid = 1'b1; wr_addr = 4'd13; wr_data = 32'h13131313; wr_be = 4'hF;
        tick();
        idle_inputs();
        rd_valid = 1'b1; rd_addr = 4'd13;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("oor B valid", {31'b0, rsp_valid_w[1]}, 32'h1);
        chk("oor B err", {31'b0, rsp_err_w[1]}, 32'h1);
        chk("oor B data", rsp_data_w[1], 32'h0);

        // reset with reads in flight: nothing may emerge
        rd_valid = 1'b1; rd_addr = 4'd1; tick();
        rd_addr = 4'd2; tick();
        res = 1'b1; tick();
        chk("midrst rd_ready B", {31'b0, rd_ready_w[1]}, 32'h0);
        chk("midrst wr_ready A", {31'b0, wr_ready_w[0]}, 32'h0);
        res = 1'b0; idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst B no rsp", {31'b0, rsp_valid_w[1]}, 32'h0);
            chk("midrst A no rsp", {31'b0, rsp_valid_w[0]}, 32'h0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            res       = ($urandom_range(0, 79) == 0);
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = 4'($urandom_range(0, 15));
            wr_data   = $urandom;
            wr_be     = 4'($urandom_range(0, 15));
            rd_valid  = ($urandom_range(0, 3) != 0);
            rd_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        res = 1'b0; rsp_ready = 1'b1; idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
